// File: rtl/ppu_vga_pkg.sv
// ppu_vga_pkg
// Shared constants and helpers for the PPU-to-VGA path.
//   - Default source picture geometry (256x240), display geometry (640x480),
//     default palette index width and border index.
//   - clog2: ceiling log2 usable in parameter/localparam expressions.
//   - flag_chk_t: the pair of ordering checks evaluated per display request.
package ppu_vga_pkg;

  localparam int DEF_PIX_W = 5;
  localparam int DEF_SRC_W = 256;
  localparam int DEF_SRC_H = 240;
  localparam int DISP_W    = 640;
  localparam int DISP_H    = 480;

  localparam logic [4:0] DEF_BORDER_IDX = 5'h0F;

  // Result of the underrun/overrun checks for one display request.
  typedef struct packed {
    logic underrun;
    logic overrun;
  } flag_chk_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    while (span < value) begin
      span   = span * 32'sd2;
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ppu_line_scaler_line_ram.sv
// line_ram
// Simple dual-port line store: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old
// contents (read-before-write). Memory contents are not reset; only the read
// data register is, so downstream logic sees a defined value after reset.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr         : read request, data appears on rd_data next edge
//   rd_data               : registered read data
module line_ram #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13,
  parameter int DW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; storage array is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ppu_line_scaler.sv
// ppu_line_scaler
// Line-buffer bridge between the PPU pixel stream and VGA scan-out.
// PPU pixels land in a ring of LINES source lines; display requests are mapped
// back to source coordinates (power-of-two scale, programmable origin) and read
// out two cycles later, or replaced by BORDER_IDX outside the picture window.
// Sticky flags report display-ahead-of-PPU (underrun) and lines overwritten
// before display (overrun).
// Ports:
//   clock, reset                       : shared clock, synchronous active-high reset
//   ppu_valid/ppu_x/ppu_y/ppu_pal_index: PPU pixel write
//   ppu_frame_start                    : start-of-frame pulse, drops the commit state
//   disp_req/disp_x/disp_y             : display read request (one per cycle max)
//   disp_valid/disp_pal_index/disp_border : result, two cycles after the request
//   flag_clear                         : clears underrun/overrun
//   underrun, overrun                  : sticky status flags
module ppu_line_scaler
  import ppu_vga_pkg::*;
#(
  parameter int               PIX_W      = DEF_PIX_W,
  parameter int               SRC_W      = DEF_SRC_W,
  parameter int               SRC_H      = DEF_SRC_H,
  parameter int               LINES      = 32,
  parameter int               SCALE_LOG2 = 1,
  parameter int               X_ORIGIN   = 64,
  parameter int               Y_ORIGIN   = 0,
  parameter logic [PIX_W-1:0] BORDER_IDX = PIX_W'(DEF_BORDER_IDX)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ppu_valid,
  input  logic [8:0]       ppu_x,
  input  logic [8:0]       ppu_y,
  input  logic [PIX_W-1:0] ppu_pal_index,
  input  logic             ppu_frame_start,
  input  logic             disp_req,
  input  logic [9:0]       disp_x,
  input  logic [9:0]       disp_y,
  output logic             disp_valid,
  output logic [PIX_W-1:0] disp_pal_index,
  output logic             disp_border,
  input  logic             flag_clear,
  output logic             underrun,
  output logic             overrun
);

  localparam int XW    = clog2(SRC_W);
  localparam int LW    = clog2(LINES);
  localparam int AW    = LW + XW;
  localparam int DEPTH = LINES * SRC_W;

  // ---------------- PPU write side ----------------
  logic          wr_ok;
  logic          commit;
  logic [AW-1:0] wr_addr;

  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [PIX_W-1:0] wr_data_q;

  logic       committed_valid;
  logic [8:0] committed_y;

  // 10-bit compare so that SRC_W == 512 is still representable.
  assign wr_ok   = ppu_valid && ({1'b0, ppu_x} < 10'(SRC_W));
  assign commit  = wr_ok && (ppu_x == 9'(SRC_W - 1));
  assign wr_addr = {ppu_y[LW-1:0], ppu_x[XW-1:0]};

  // Write port is staged one cycle so it lines up with the read stage: a
  // request issued alongside a write sees the old data, the next one sees new.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_ok;
      wr_addr_q <= wr_addr;
      wr_data_q <= ppu_pal_index;
    end
  end

  // Commit tracker; a commit coinciding with frame start wins (clear then commit).
  always_ff @(posedge clock) begin
    if (reset) begin
      committed_valid <= 1'b0;
      committed_y     <= 9'd0;
    end else if (commit) begin
      committed_valid <= 1'b1;
      committed_y     <= ppu_y;
    end else if (ppu_frame_start) begin
      committed_valid <= 1'b0;
    end
  end

  // ---------------- Display coordinate map ----------------
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] sx;
  logic signed [10:0] sy;
  logic               in_win;
  logic [AW-1:0]      rd_addr;
  flag_chk_t          chk;

  assign dx = $signed({1'b0, disp_x}) - $signed(11'(X_ORIGIN));
  assign dy = $signed({1'b0, disp_y}) - $signed(11'(Y_ORIGIN));
  assign sx = dx >>> SCALE_LOG2;
  assign sy = dy >>> SCALE_LOG2;

  // Sign bits reject the left/top margins; sx/sy are non-negative past that.
  assign in_win = !dx[10] && !dy[10] &&
                  ($unsigned(sx) < 11'(SRC_W)) && ($unsigned(sy) < 11'(SRC_H));

  assign rd_addr = {sy[LW-1:0], sx[XW-1:0]};

  // Overrun: the newest committed line has lapped the ring past the requested one.
  assign chk.underrun = !committed_valid || ($unsigned(sy) > {2'b00, committed_y});
  assign chk.overrun  = committed_valid &&
                        ({1'b0, committed_y} >= (sy[9:0] + 10'(LINES)));

  // ---------------- Read pipeline ----------------
  logic          s1_valid;
  logic          s1_in_win;
  logic [AW-1:0] s1_addr;
  logic [PIX_W-1:0] ram_data;

  // Stage 1: capture address and window decision.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_in_win <= 1'b0;
      s1_addr   <= '0;
    end else begin
      s1_valid  <= disp_req;
      s1_in_win <= in_win;
      s1_addr   <= rd_addr;
    end
  end

  // Stage 2: result strobe and border marker, aligned with the RAM read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_valid  <= 1'b0;
      disp_border <= 1'b0;
    end else begin
      disp_valid  <= s1_valid;
      disp_border <= s1_valid && !s1_in_win;
    end
  end

  line_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (PIX_W)
  ) u_line_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_en   (s1_valid && s1_in_win),
    .rd_addr (s1_addr),
    .rd_data (ram_data)
  );

  // Both operands are registers, both reset to zero.
  assign disp_pal_index = disp_border ? BORDER_IDX : ram_data;

  // ---------------- Sticky flags ----------------
  // Set events from the current request take priority over flag_clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (disp_req && in_win && chk.underrun) begin
        underrun <= 1'b1;
      end else if (flag_clear) begin
        underrun <= 1'b0;
      end
      if (disp_req && in_win && chk.overrun) begin
        overrun <= 1'b1;
      end else if (flag_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
